// File: rtl/lfsr_rng_pkg.sv
// Shared types, widths and the LFSR polynomial for the random-word arbiter.
package lfsr_rng_pkg;

  localparam int unsigned RAND_W        = 64;
  localparam int unsigned GRANT_CNT_W   = 32;
  localparam int unsigned ABANDON_CNT_W = 16;

  localparam logic [RAND_W-1:0] LFSR_SEED = 64'hdeadbeef12345678;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STEP   = 2'd2,
    ST_GRANT  = 2'd3
  } state_e;

  // One Fibonacci step, taps 64,63,61,60, new bit enters at the LSB.
  function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] s);
    return {s[RAND_W-2:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

endpackage

// File: rtl/lfsr64.sv
// 64-bit maximal-length LFSR with hold enable; reseeds on reset.
module lfsr64
  import lfsr_rng_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [RAND_W-1:0] state
);

  logic [RAND_W-1:0] state_q;
  logic [RAND_W-1:0] state_d;

  // Advance one step when enabled, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (enable) state_d = lfsr_next(state_q);
  end

  // State register, seeded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LFSR_SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_rng_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first set request at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner_c,
  output logic               any_req_c
);

  // Scan requesters in circular order starting at the pointer.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx      = 0;
    found    = 1'b0;
    winner_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found    = 1'b1;
        winner_c = IDX_W'(idx);
      end
    end
  end

  assign any_req_c = |req;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter handing out one decorrelated 64-bit LFSR word per grant.
module lfsr_rng_arbiter
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned STRIDE        = 8,
  parameter int unsigned WARMUP_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [RAND_W-1:0]        rand_data,
  output logic                     busy,
  output logic [GRANT_CNT_W-1:0]   grant_count,
  output logic [ABANDON_CNT_W-1:0] abandon_count
);

  localparam int unsigned IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX   = (WARMUP_CYCLES > STRIDE) ? WARMUP_CYCLES : STRIDE;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned WARM_LAST = (WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1;
  localparam int unsigned STEP_LAST = STRIDE - 1;
  localparam bit          NO_WARMUP = (WARMUP_CYCLES == 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         winner_q, winner_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [RAND_W-1:0]        rand_data_q, rand_data_d;
  logic                     busy_q, busy_d;
  logic [GRANT_CNT_W-1:0]   grant_count_q, grant_count_d;
  logic [ABANDON_CNT_W-1:0] abandon_count_q, abandon_count_d;

  logic                     lfsr_en_c;
  logic                     lfsr_rst_c;
  logic [RAND_W-1:0]        lfsr_state;
  logic [IDX_W-1:0]         arb_winner_c;
  logic                     arb_any_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .winner_c  (arb_winner_c),
    .any_req_c (arb_any_c)
  );

  assign lfsr_rst_c = ~rst_n;

  lfsr64 u_lfsr (
    .clk    (clk),
    .rst    (lfsr_rst_c),
    .enable (lfsr_en_c),
    .state  (lfsr_state)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WARMUP;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WARMUP: if (NO_WARMUP || cnt_q == CNT_W'(WARM_LAST)) state_d = ST_IDLE;
      ST_IDLE:   if (arb_any_c) state_d = ST_STEP;
      ST_STEP:   if (cnt_q == CNT_W'(STEP_LAST)) state_d = ST_GRANT;
      ST_GRANT:  state_d = ST_IDLE;
      default:   state_d = ST_WARMUP;
    endcase
  end

  // LFSR enable and next values of every registered output and bookkeeping flop.
  // The grant decision is taken on the last STEP edge so gnt/rand_data are
  // registered yet visible exactly in the GRANT cycle.
  always_comb begin
    lfsr_en_c       = 1'b0;
    cnt_d           = cnt_q;
    rr_ptr_d        = rr_ptr_q;
    winner_d        = winner_q;
    gnt_d           = '0;
    rand_data_d     = rand_data_q;
    grant_count_d   = grant_count_q;
    abandon_count_d = abandon_count_q;
    busy_d          = (state_d != ST_IDLE);
    case (state_q)
      ST_WARMUP: begin
        lfsr_en_c = !NO_WARMUP;
        cnt_d     = (state_d == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (arb_any_c) winner_d = arb_winner_c;
      end
      ST_STEP: begin
        lfsr_en_c = 1'b1;
        cnt_d     = (state_d == ST_GRANT) ? '0 : cnt_q + CNT_W'(1);
        if (state_d == ST_GRANT) begin
          if (req[winner_q]) begin
            gnt_d[winner_q] = 1'b1;
            rand_data_d     = lfsr_next(lfsr_state);
            grant_count_d   = grant_count_q + GRANT_CNT_W'(1);
          end else if (abandon_count_q != '1) begin
            abandon_count_d = abandon_count_q + ABANDON_CNT_W'(1);
          end
        end
      end
      ST_GRANT: begin
        rr_ptr_d = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      rr_ptr_q        <= '0;
      winner_q        <= '0;
      gnt_q           <= '0;
      rand_data_q     <= '0;
      busy_q          <= 1'b1;
      grant_count_q   <= '0;
      abandon_count_q <= '0;
    end else begin
      cnt_q           <= cnt_d;
      rr_ptr_q        <= rr_ptr_d;
      winner_q        <= winner_d;
      gnt_q           <= gnt_d;
      rand_data_q     <= rand_data_d;
      busy_q          <= busy_d;
      grant_count_q   <= grant_count_d;
      abandon_count_q <= abandon_count_d;
    end
  end

  assign gnt           = gnt_q;
  assign rand_data     = rand_data_q;
  assign busy          = busy_q;
  assign grant_count   = grant_count_q;
  assign abandon_count = abandon_count_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Randomized self-checking bench for lfsr_rng_arbiter against a word-count model.
module tb_lfsr_rng_arbiter;

  localparam logic [63:0] SEED = 64'hdeadbeef12345678;
  localparam int WARM = 64;
  localparam int STR  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [63:0] rand_data;
  logic        busy;
  logic [31:0] grant_count;
  logic [15:0] abandon_count;

  // no-warmup, single-step instance
  logic        rst_n_s;
  logic [3:0]  req_s;
  logic [3:0]  gnt_s;
  logic [63:0] rand_data_s;
  logic        busy_s;
  logic [31:0] grant_count_s;
  logic [15:0] abandon_count_s;

  lfsr_rng_arbiter #(.NUM_REQ(4), .STRIDE(8), .WARMUP_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rand_data(rand_data),
    .busy(busy), .grant_count(grant_count), .abandon_count(abandon_count)
  );

  lfsr_rng_arbiter #(.NUM_REQ(4), .STRIDE(1), .WARMUP_CYCLES(0)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .req(req_s), .gnt(gnt_s), .rand_data(rand_data_s),
    .busy(busy_s), .grant_count(grant_count_s), .abandon_count(abandon_count_s)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pointer, total LFSR steps taken, statistics.
  int          m_ptr;
  int          m_steps;
  logic [31:0] m_gc;
  logic [15:0] m_ac;

  function automatic logic [63:0] golden(input int n);
    logic [63:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    return s;
  endfunction

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_steps = WARM; m_gc = '0; m_ac = '0;
  endtask

  task automatic model_round(input logic [3:0] r, input bit dropped,
                             output int w, output logic [63:0] exp_d);
    w = pick(r, m_ptr);
    m_steps += STR;
    exp_d = golden(m_steps);
    if (dropped) begin
      if (m_ac != 16'hFFFF) m_ac++;
    end else begin
      m_gc++;
    end
    m_ptr = (w + 1) % 4;
  endtask

  // Drive one request from an IDLE negedge, observe STR+2 cycles, end in IDLE.
  task automatic do_round(input logic [3:0] r, input int drop_at,
                          output int gnt_cyc, output int n_gnt,
                          output logic [3:0] g, output logic [63:0] d);
    gnt_cyc = -1; n_gnt = 0; g = '0; d = '0;
    req = r;
    for (int c = 1; c <= STR + 2; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        n_gnt++;
        if (gnt_cyc < 0) begin gnt_cyc = c; g = gnt; d = rand_data; end
      end
      if (c == drop_at) req = '0;
      if (c == STR + 1) req = '0;
    end
  endtask

  task automatic test_small();
    req_s = 4'b0001;
    @(negedge clk);
    checks++; if (gnt_s !== 4'b0000) begin errors++; $display("FAIL small_rst_gnt: got %b expected 0000", gnt_s); end
    checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL small_rst_busy: got %b expected 1", busy_s); end
    rst_n_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt_s !== 4'b0000) begin errors++; $display("FAIL small_early_gnt: got %b expected 0000", gnt_s); end
    @(negedge clk);
    checks++; if (gnt_s !== 4'b0001) begin errors++; $display("FAIL small_gnt: got %b expected 0001", gnt_s); end
    checks++; if (rand_data_s !== 64'hbd5b7dde2468acf0) begin errors++; $display("FAIL small_data: got %h expected bd5b7dde2468acf0", rand_data_s); end
    checks++; if (grant_count_s !== 32'd1) begin errors++; $display("FAIL small_gcount: got %0d expected 1", grant_count_s); end
    req_s = 4'b0000;
    @(negedge clk);
    checks++; if (gnt_s !== 4'b0000) begin errors++; $display("FAIL small_pulse: got %b expected 0000", gnt_s); end
  endtask

  task automatic test_reset();
    int seen;
    req = '0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    checks++; if (rand_data !== 64'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", rand_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
    checks++; if (grant_count !== 32'd0) begin errors++; $display("FAIL rst_gcount: got %0d expected 0", grant_count); end
    checks++; if (abandon_count !== 16'd0) begin errors++; $display("FAIL rst_acount: got %0d expected 0", abandon_count); end
    model_reset();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 1; c <= WARM; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) seen++;
      if (c == WARM - 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL warm_busy: got %b expected 1", busy); end
      end
      if (c == WARM) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL warm_idle: got %b expected 0", busy); end
      end
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL warm_gnt: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  gv [4];
    logic [63:0] dv [4];
    int          cy [4];
    int          n, w;
    logic [63:0] ed;
    n = 0;
    req = 4'b1111;
    for (int c = 1; c <= 4 * (STR + 2); c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        if (n < 4) begin gv[n] = gnt; dv[n] = rand_data; cy[n] = c; end
        n++;
        if (n == 4) req = '0;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      model_round(4'b1111, 1'b0, w, ed);
      checks++; if (gv[k] !== 4'(1 << w)) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, gv[k], 4'(1 << w)); end
      checks++; if (cy[k] != STR + 1 + k * (STR + 2)) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", k, cy[k], STR + 1 + k * (STR + 2)); end
      checks++; if (dv[k] !== ed) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, dv[k], ed); end
      for (int j = 0; j < k; j++) begin
        checks++; if (dv[k] === dv[j]) begin errors++; $display("FAIL b2b_distinct[%0d,%0d]: got %h twice expected distinct", j, k, dv[k]); end
      end
    end
    checks++; if (grant_count !== m_gc) begin errors++; $display("FAIL b2b_gcount: got %0d expected %0d", grant_count, m_gc); end
  endtask

  task automatic test_rotation();
    logic [3:0]  pat [3];
    int          cyc, ng, w;
    logic [3:0]  g;
    logic [63:0] d, ed;
    pat[0] = 4'b0100; pat[1] = 4'b0101; pat[2] = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      do_round(pat[k], 0, cyc, ng, g, d);
      model_round(pat[k], 1'b0, w, ed);
      checks++; if (g !== 4'(1 << w) || ng != 1) begin errors++; $display("FAIL rot_gnt[%0d]: got %b (%0d pulses) expected %b", k, g, ng, 4'(1 << w)); end
      checks++; if (d !== ed) begin errors++; $display("FAIL rot_data[%0d]: got %h expected %h", k, d, ed); end
    end
  endtask

  task automatic test_abandon();
    int          cyc, ng, w;
    logic [3:0]  g;
    logic [63:0] d, ed;
    do_round(4'b0010, 3, cyc, ng, g, d);
    model_round(4'b0010, 1'b1, w, ed);
    checks++; if (ng != 0) begin errors++; $display("FAIL ab_gnt: got %0d pulses expected 0", ng); end
    checks++; if (abandon_count !== m_ac) begin errors++; $display("FAIL ab_acount: got %0d expected %0d", abandon_count, m_ac); end
    checks++; if (grant_count !== m_gc) begin errors++; $display("FAIL ab_gcount: got %0d expected %0d", grant_count, m_gc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b expected 0", busy); end
    do_round(4'b0101, 0, cyc, ng, g, d);
    model_round(4'b0101, 1'b0, w, ed);
    checks++; if (g !== 4'(1 << w)) begin errors++; $display("FAIL ab_next_gnt: got %b expected %b", g, 4'(1 << w)); end
    checks++; if (d !== ed) begin errors++; $display("FAIL ab_next_data: got %h expected %h", d, ed); end
  endtask

  task automatic test_reset_mid_step();
    int          cyc, ng, w, seen;
    logic [3:0]  g;
    logic [63:0] d, ed;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL mid_rst_ctl: got gnt=%b busy=%b expected 0000/1", gnt, busy); end
    checks++; if (grant_count !== 32'd0 || abandon_count !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d/%0d expected 0/0", grant_count, abandon_count); end
    checks++; if (rand_data !== 64'd0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", rand_data); end
    req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (WARM) begin
      @(negedge clk);
      if (gnt !== 4'b0000) seen++;
    end
    checks++; if (seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_warm: got pulses=%0d busy=%b expected 0/0", seen, busy); end
    do_round(4'b0001, 0, cyc, ng, g, d);
    model_round(4'b0001, 1'b0, w, ed);
    checks++; if (g !== 4'b0001 || cyc != STR + 1) begin errors++; $display("FAIL mid_gnt: got %b at %0d expected 0001 at %0d", g, cyc, STR + 1); end
    checks++; if (d !== ed) begin errors++; $display("FAIL mid_data: got %h expected %h", d, ed); end
  endtask

  task automatic test_counter_wrap();
    int          w, ng;
    logic [63:0] ed;
    req = 4'b0001;
    for (int c = 1; c <= STR + 2; c++) begin
      @(negedge clk);
      if (c == 3) begin force dut.grant_count_q = 32'hFFFFFFFF; m_gc = 32'hFFFFFFFF; end
      if (c == 4) release dut.grant_count_q;
      if (c == STR + 1) begin
        model_round(4'b0001, 1'b0, w, ed);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b expected 0001", gnt); end
        checks++; if (grant_count !== m_gc) begin errors++; $display("FAIL wrap_gcount: got %h expected %h", grant_count, m_gc); end
        req = '0;
      end
    end
    ng = 0;
    req = 4'b1000;
    for (int c = 1; c <= STR + 2; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) ng++;
      if (c == 3) begin force dut.abandon_count_q = 16'hFFFF; m_ac = 16'hFFFF; end
      if (c == 4) release dut.abandon_count_q;
      if (c == 5) req = '0;
    end
    model_round(4'b1000, 1'b1, w, ed);
    checks++; if (abandon_count !== m_ac || ng != 0) begin errors++; $display("FAIL sat_acount: got %h (%0d pulses) expected %h", abandon_count, ng, m_ac); end
  endtask

  task automatic test_random();
    int          cyc, ng, w, drop;
    logic [3:0]  r, g;
    logic [63:0] d, ed;
    for (int k = 0; k < 16; k++) begin
      r    = 4'($urandom_range(1, 15));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      do_round(r, drop, cyc, ng, g, d);
      model_round(r, drop != 0, w, ed);
      if (drop != 0) begin
        checks++; if (ng != 0) begin errors++; $display("FAIL rnd_drop[%0d]: got %0d pulses expected 0", k, ng); end
      end else begin
        checks++; if (ng != 1 || g !== 4'(1 << w) || cyc != STR + 1) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b x%0d at %0d expected %b at %0d", k, g, ng, cyc, 4'(1 << w), STR + 1); end
        checks++; if (d !== ed) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", k, d, ed); end
      end
      checks++; if (grant_count !== m_gc || abandon_count !== m_ac) begin errors++; $display("FAIL rnd_counts[%0d]: got %0d/%0d expected %0d/%0d", k, grant_count, abandon_count, m_gc, m_ac); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected 0", k, busy); end
    end
  endtask

  initial begin
    rst_n = 1'b1; rst_n_s = 1'b1; req = '0; req_s = '0;
    #2;
    rst_n = 1'b0; rst_n_s = 1'b0;
    test_small();
    test_reset();
    test_back_to_back();
    test_rotation();
    test_abandon();
    test_reset_mid_step();
    test_counter_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
